alu_seq_ctrl: RTL and testbench

- Multi-cycle instruction sequencer that drives the combinational ALU.
- Accepts 16-bit instruction words over a valid/ready handshake and reads two operands from the external register file.
- Presents the ALU opcode and operands, captures the result and flags, writes the result back, and holds the processor status register (PSR) that feeds back as ALU flags_in.
- Sits between instruction fetch, register file and ALU.

---
 rtl/alu_seq_ctrl_if.sv | 38 +++
 rtl/alu_seq_ctrl.sv | 127 ++++++++++++
 tb/tb_alu_seq_ctrl.sv | 288 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_seq_ctrl_if.sv
// Bundle of the instruction handshake, register-file and ALU signals of alu_seq_ctrl.
// The slave modport is the sequencer's view; master is the surrounding datapath's view.
interface alu_seq_ctrl_if #(
   parameter int DATA_W = 16
);
   logic              instr_valid;
   logic              instr_ready;
   logic [15:0]       instr;
   logic [3:0]        rf_raddr_a;
   logic [3:0]        rf_raddr_b;
   logic [DATA_W-1:0] rf_rdata_a;
   logic [DATA_W-1:0] rf_rdata_b;
   logic              rf_we;
   logic [3:0]        rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic [7:0]        alu_opcode;
   logic [DATA_W-1:0] alu_r1;
   logic [DATA_W-1:0] alu_r2;
   logic [7:0]        alu_flags_in;
   logic [DATA_W-1:0] alu_rout;
   logic [7:0]        alu_flags_out;
   logic [7:0]        psr;
   logic              illegal_op;
   logic              retire;
   logic              busy;

   modport slave (
      input  instr_valid, instr, rf_rdata_a, rf_rdata_b, alu_rout, alu_flags_out,
      output instr_ready, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
             alu_opcode, alu_r1, alu_r2, alu_flags_in, psr, illegal_op, retire, busy
   );

   modport master (
      output instr_valid, instr, rf_rdata_a, rf_rdata_b, alu_rout, alu_flags_out,
      input  instr_ready, rf_raddr_a, rf_raddr_b, rf_we, rf_waddr, rf_wdata,
             alu_opcode, alu_r1, alu_r2, alu_flags_in, psr, illegal_op, retire, busy
   );
endinterface

// File: rtl/alu_seq_ctrl.sv
// Multi-cycle FETCH/DECODE/EXEC/WB sequencer driving an external combinational ALU and register file.
// Optional macro ALU_SEQ_HALT_ON_ILLEGAL_EN: an illegal opcode parks the sequencer in HALT until reset.
module alu_seq_ctrl #(
   parameter int          DATA_W    = 16,
   parameter logic [7:0]  PSR_RESET = 8'h00
) (
   input  logic            clk,
   input  logic            rst_n,
   alu_seq_ctrl_if.slave   bus
);

   localparam logic [2:0] S_FETCH  = 3'd0;
   localparam logic [2:0] S_DECODE = 3'd1;
   localparam logic [2:0] S_EXEC   = 3'd2;
   localparam logic [2:0] S_WB     = 3'd3;
`ifdef ALU_SEQ_HALT_ON_ILLEGAL_EN
   localparam logic [2:0] S_HALT   = 3'd4;
`endif

   localparam logic [7:0] OP_ADD = 8'h05;
   localparam logic [7:0] OP_SUB = 8'h09;
   localparam logic [7:0] OP_CMP = 8'h0B;

   // Flag positions the PSR takes from the ALU: C/F for add/sub, L/Z/N for compare.
   localparam logic [7:0] MASK_ARITH = 8'h21;
   localparam logic [7:0] MASK_CMP   = 8'hC4;

   logic [2:0]        r_state;
   logic [15:0]       r_instr;
   logic [7:0]        r_aluOpcode;
   logic [DATA_W-1:0] r_aluR1;
   logic [DATA_W-1:0] r_aluR2;
   logic [3:0]        r_wAddr;
   logic [DATA_W-1:0] r_wData;
   logic [7:0]        r_psr;
   logic              r_illegalOp;

   logic              w_legal;
   logic              w_unused;

   always_comb begin
      case (r_instr[15:8])
         8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
         8'h08, 8'h09, 8'h0B, 8'h0C, 8'h0F, 8'h84: w_legal = 1'b1;
         default:                                 w_legal = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_FETCH;
         r_instr     <= '0;
         r_aluOpcode <= '0;
         r_aluR1     <= '0;
         r_aluR2     <= '0;
         r_wAddr     <= '0;
         r_wData     <= '0;
         r_psr       <= PSR_RESET;
         r_illegalOp <= 1'b0;
      end else begin
         r_illegalOp <= 1'b0;
         case (r_state)
            S_FETCH: begin
               if (bus.instr_valid) begin
                  r_instr <= bus.instr;
                  r_state <= S_DECODE;
               end
            end
            S_DECODE: begin
               r_aluR1     <= bus.rf_rdata_a;
               r_aluR2     <= bus.rf_rdata_b;
               r_aluOpcode <= r_instr[15:8];
               if (w_legal) begin
                  r_state <= S_EXEC;
               end else begin
                  r_illegalOp <= 1'b1;
`ifdef ALU_SEQ_HALT_ON_ILLEGAL_EN
                  r_state     <= S_HALT;
`else
                  r_state     <= S_FETCH;
`endif
               end
            end
            S_EXEC: begin
               r_wData <= bus.alu_rout;
               r_wAddr <= r_instr[7:4];
               case (r_aluOpcode)
                  OP_ADD, OP_SUB: r_psr <= (r_psr & ~MASK_ARITH) | (bus.alu_flags_out & MASK_ARITH);
                  OP_CMP:         r_psr <= (r_psr & ~MASK_CMP)   | (bus.alu_flags_out & MASK_CMP);
                  default:        r_psr <= r_psr;
               endcase
               r_state <= S_WB;
            end
            S_WB: begin
               r_state <= S_FETCH;
            end
`ifdef ALU_SEQ_HALT_ON_ILLEGAL_EN
            S_HALT: begin
               r_state <= S_HALT;
            end
`endif
            default: begin
               r_state <= S_FETCH;
            end
         endcase
      end
   end

   // Strobes are state decodes so an asynchronous reset drops them in the same instant.
   assign bus.instr_ready  = (r_state == S_FETCH);
   assign bus.busy         = (r_state != S_FETCH);
   assign bus.retire       = (r_state == S_WB);
   assign bus.rf_we        = (r_state == S_WB) && (r_aluOpcode != OP_CMP);
   assign bus.rf_raddr_a   = r_instr[3:0];
   assign bus.rf_raddr_b   = r_instr[7:4];
   assign bus.rf_waddr     = r_wAddr;
   assign bus.rf_wdata     = r_wData;
   assign bus.alu_opcode   = r_aluOpcode;
   assign bus.alu_r1       = r_aluR1;
   assign bus.alu_r2       = r_aluR2;
   assign bus.alu_flags_in = r_psr;
   assign bus.psr          = r_psr;
   assign bus.illegal_op   = r_illegalOp;

   assign w_unused = &{1'b0, bus.alu_flags_out[4:3], bus.alu_flags_out[1]};

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed bench for alu_seq_ctrl with a behavioural register file and ALU around it.
// Retired instructions are checked against a scoreboard filled when each instruction is accepted.
module tb_alu_seq_ctrl;

   logic clk;
   logic rst_n;

   alu_seq_ctrl_if #(.DATA_W(16)) bus ();

   alu_seq_ctrl #(.DATA_W(16), .PSR_RESET(8'h01)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        we;
      logic [3:0]  addr;
      logic [15:0] data;
      logic [7:0]  psr;
      int          acc;
   } exp_t;

   exp_t        sb[$];
   int          compared   = 0;
   int          mismatched = 0;
   int          cyc        = 0;
   int          weCount    = 0;
   int          illCount   = 0;
   int          retCount   = 0;
   logic [15:0] rf [16];
   logic        pokeEn     = 1'b0;
   logic [3:0]  pokeAddr   = '0;
   logic [15:0] pokeData   = '0;
   logic [15:0] aluRout;
   logic [7:0]  aluFlags;
   logic [16:0] aluSum;
   bit          haltMode;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Register file: combinational reads, writes from the DUT or from bench pokes.
   assign bus.rf_rdata_a = rf[bus.rf_raddr_a];
   assign bus.rf_rdata_b = rf[bus.rf_raddr_b];
   always @(posedge clk) begin
      if (bus.rf_we) rf[bus.rf_waddr] <= bus.rf_wdata;
      if (pokeEn)    rf[pokeAddr]     <= pokeData;
   end

   // Behavioural ALU: flags C=0, L=2, F=5, Z=6, N=7.
   always_comb begin
      aluSum   = '0;
      aluRout  = bus.alu_r1 ^ bus.alu_r2;
      aluFlags = '0;
      case (bus.alu_opcode)
         8'h05: begin
            aluSum      = {1'b0, bus.alu_r1} + {1'b0, bus.alu_r2};
            aluRout     = aluSum[15:0];
            aluFlags[0] = aluSum[16];
            aluFlags[5] = (bus.alu_r1[15] == bus.alu_r2[15]) && (aluSum[15] != bus.alu_r1[15]);
         end
         8'h07: begin
            aluSum      = {1'b0, bus.alu_r1} + {1'b0, bus.alu_r2} + {16'd0, bus.alu_flags_in[0]};
            aluRout     = aluSum[15:0];
            aluFlags[0] = aluSum[16];
            aluFlags[5] = (bus.alu_r1[15] == bus.alu_r2[15]) && (aluSum[15] != bus.alu_r1[15]);
         end
         8'h09: begin
            aluSum      = {1'b0, bus.alu_r2} - {1'b0, bus.alu_r1};
            aluRout     = aluSum[15:0];
            aluFlags[0] = aluSum[16];
            aluFlags[5] = (bus.alu_r1[15] != bus.alu_r2[15]) && (aluSum[15] != bus.alu_r2[15]);
         end
         default: begin
         end
      endcase
      aluFlags[6] = (aluRout == 16'h0000);
      aluFlags[7] = aluRout[15];
      if (bus.alu_opcode == 8'h0B) begin
         aluRout     = bus.alu_r2 - bus.alu_r1;
         aluFlags    = '0;
         aluFlags[2] = (bus.alu_r2 < bus.alu_r1);
         aluFlags[6] = (bus.alu_r2 == bus.alu_r1);
         aluFlags[7] = ($signed(bus.alu_r2) < $signed(bus.alu_r1));
      end
   end
   assign bus.alu_rout      = aluRout;
   assign bus.alu_flags_out = aluFlags;

   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: retire pops the oldest accepted instruction; retire falls 3 cycles after the accept cycle.
   always @(negedge clk) begin
      if (bus.rf_we)      weCount++;
      if (bus.illegal_op) illCount++;
      if (bus.retire) begin
         exp_t e;
         retCount++;
         checkOutput("retire_pending", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            checkOutput("wb_we", 32'(bus.rf_we), 32'(e.we));
            checkOutput("wb_psr", 32'(bus.psr), 32'(e.psr));
            checkOutput("wb_latency", 32'(cyc - e.acc), 32'd3);
            if (e.we) begin
               checkOutput("wb_addr", 32'(bus.rf_waddr), 32'(e.addr));
               checkOutput("wb_data", 32'(bus.rf_wdata), 32'(e.data));
            end
         end
      end
   end

   task automatic pokeReg(input logic [3:0] a, input logic [15:0] d);
      pokeEn   = 1'b1;
      pokeAddr = a;
      pokeData = d;
      @(posedge clk);
      #1;
      pokeEn   = 1'b0;
   endtask

   // Offers one instruction; on acceptance optionally queues its expected writeback.
   task automatic applyStimulus(input logic [15:0] ins, input bit push, input logic we,
                                input logic [3:0] a, input logic [15:0] d, input logic [7:0] p,
                                output int accCyc);
      exp_t e;
      int   n;
      bus.instr       = ins;
      bus.instr_valid = 1'b1;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!bus.instr_ready && n < 20);
      accCyc = cyc;
      checkOutput("accept_seen", 32'(bus.instr_ready), 32'd1);
      if (push && bus.instr_ready) begin
         e.we = we; e.addr = a; e.data = d; e.psr = p; e.acc = cyc;
         sb.push_back(e);
      end
      @(posedge clk);
      #1;
      bus.instr_valid = 1'b0;
   endtask

   task automatic waitIdle();
      int n;
      n = 0;
      while ((sb.size() != 0 || !bus.instr_ready) && n < 30) begin
         @(negedge clk);
         n++;
      end
      checkOutput("idle_reached", 32'(sb.size() == 0 && bus.instr_ready), 32'd1);
      @(posedge clk);
      #1;
   endtask

   task automatic doReset();
      rst_n = 1'b0;
      @(negedge clk);
      checkOutput("rst_ready", 32'(bus.instr_ready), 32'd1);
      checkOutput("rst_busy", 32'(bus.busy), 32'd0);
      checkOutput("rst_psr", 32'(bus.psr), 32'h01);
      checkOutput("rst_we", 32'(bus.rf_we), 32'd0);
      checkOutput("rst_retire", 32'(bus.retire), 32'd0);
      checkOutput("rst_illegal", 32'(bus.illegal_op), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL global_timeout");
      $fatal(1, "[TB] bench did not finish");
   end

   initial begin
      int a1, a2, a3, aIll, weBefore, illBefore;
`ifdef ALU_SEQ_HALT_ON_ILLEGAL_EN
      haltMode = 1'b1;
`else
      haltMode = 1'b0;
`endif
      rst_n           = 1'b0;
      bus.instr_valid = 1'b0;
      bus.instr       = '0;
      @(posedge clk);
      #1;
      doReset();
      checkOutput("rst_opcode", 32'(bus.alu_opcode), 32'h00);

      // ADDC consumes the reset carry: 2 + 3 + 1 = 6 into R5, psr untouched.
      pokeReg(4'h5, 16'h0002);
      pokeReg(4'h6, 16'h0003);
      applyStimulus(16'h0756, 1'b1, 1'b1, 4'h5, 16'h0006, 8'h01, a1);
      waitIdle();
      checkOutput("addc_r5", 32'(rf[5]), 32'h0006);

      // ADD overflow: 0001 + 7FFF = 8000, C cleared, F set.
      pokeReg(4'h3, 16'h7FFF);
      pokeReg(4'h4, 16'h0001);
      applyStimulus(16'h0534, 1'b1, 1'b1, 4'h3, 16'h8000, 8'h20, a1);
      waitIdle();
      checkOutput("add_r1", 32'(bus.alu_r1), 32'h0001);
      checkOutput("add_r2", 32'(bus.alu_r2), 32'h7FFF);
      checkOutput("add_opcode", 32'(bus.alu_opcode), 32'h05);
      checkOutput("add_flags_in", 32'(bus.alu_flags_in), 32'h20);
      checkOutput("add_r3", 32'(rf[3]), 32'h8000);

      // CMP of equal values: Z set, L/N clear, no writeback.
      pokeReg(4'h1, 16'h1234);
      pokeReg(4'h2, 16'h1234);
      weBefore = weCount;
      applyStimulus(16'h0B12, 1'b1, 1'b0, 4'h1, 16'h0000, 8'h60, a1);
      waitIdle();
      checkOutput("cmp_no_we", 32'(weCount - weBefore), 32'd0);

      // Illegal opcode: single illegal_op pulse two cycles after accept.
      weBefore  = weCount;
      illBefore = illCount;
      applyStimulus(16'hEE12, 1'b0, 1'b0, 4'h0, 16'h0000, 8'h00, aIll);
      @(negedge clk);
      checkOutput("ill_decode_busy", 32'(bus.busy), 32'd1);
      checkOutput("ill_not_yet", 32'(bus.illegal_op), 32'd0);
      @(negedge clk);
      checkOutput("ill_pulse", 32'(bus.illegal_op), 32'd1);
      checkOutput("ill_ready", 32'(bus.instr_ready), 32'(!haltMode));
      checkOutput("ill_psr", 32'(bus.psr), 32'h60);
      checkOutput("ill_opcode", 32'(bus.alu_opcode), 32'hEE);
      repeat (3) @(negedge clk);
      checkOutput("ill_ready_later", 32'(bus.instr_ready), 32'(!haltMode));
      checkOutput("ill_count", 32'(illCount - illBefore), 32'd1);
      checkOutput("ill_no_we", 32'(weCount - weBefore), 32'd0);
      @(posedge clk);
      #1;
      doReset();

      // Back-to-back ADDs with instr_valid held high.
      pokeReg(4'h7, 16'h0010);
      pokeReg(4'h8, 16'h0020);
      pokeReg(4'h9, 16'hFFFF);
      pokeReg(4'h0, 16'h0001);
      pokeReg(4'hA, 16'h1000);
      applyStimulus(16'h0578, 1'b1, 1'b1, 4'h7, 16'h0030, 8'h00, a1);
      applyStimulus(16'h0590, 1'b1, 1'b1, 4'h9, 16'h0000, 8'h01, a2);
      applyStimulus(16'h05A1, 1'b1, 1'b1, 4'hA, 16'h2234, 8'h00, a3);
      waitIdle();
      checkOutput("b2b_gap1", 32'(a2 - a1), 32'd4);
      checkOutput("b2b_gap2", 32'(a3 - a2), 32'd4);
      checkOutput("b2b_r9", 32'(rf[9]), 32'h0000);

      // Reset during EXEC of an ADD: no writeback, psr back to its reset value.
      weBefore = weCount;
      applyStimulus(16'h0534, 1'b0, 1'b0, 4'h0, 16'h0000, 8'h00, a1);
      @(negedge clk);
      @(negedge clk);
      checkOutput("midrst_in_exec", 32'(bus.busy), 32'd1);
      rst_n = 1'b0;
      #1;
      checkOutput("midrst_we", 32'(bus.rf_we), 32'd0);
      checkOutput("midrst_retire", 32'(bus.retire), 32'd0);
      checkOutput("midrst_psr", 32'(bus.psr), 32'h01);
      checkOutput("midrst_ready", 32'(bus.instr_ready), 32'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (6) @(negedge clk);
      checkOutput("midrst_ready_after", 32'(bus.instr_ready), 32'd1);
      checkOutput("midrst_no_we", 32'(weCount - weBefore), 32'd0);
      checkOutput("midrst_r3", 32'(rf[3]), 32'h8000);
      checkOutput("retire_total", 32'(retCount), 32'd6);
      checkOutput("sb_drained", 32'(sb.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
